// File: rtl/serneg_pkg.sv
// Shared definitions for the bit-serial negator controller:
// state encoding, latency bound and the most-negative constant helper.
package serneg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SER_LAT_MAX = 4;

  // Value 1 followed by width-1 zeros; callers truncate to their own width.
  function automatic logic [63:0] most_neg(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/serneg_if.sv
// Parallel word handshake between producer/consumer and the serial negator controller.
interface serneg_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/serneg_capture.sv
// Tracks issued serial bits through the negator latency and shifts the
// returned ser_y stream into a parallel result, LSB arriving first.
module serneg_capture
  import serneg_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SER_LAT = 1
) (
  input  logic             t_clk,
  input  logic             r_n,
  input  logic             issue,
  input  logic             ser_y,
  output logic [WIDTH-1:0] res,
  output logic             cap_done
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             cap_en;
  logic [CNT_W-1:0] cap_cnt;

  generate
    if (SER_LAT == 0) begin : g_nodly
      assign cap_en = issue;
    end else begin : g_dly
      logic [SER_LAT-1:0] dly;

      always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
          dly <= '0;
        end else begin
          dly[0] <= issue;
          for (int i = 1; i < SER_LAT; i++) begin
            dly[i] <= dly[i-1];
          end
        end
      end

      assign cap_en = dly[SER_LAT-1];
    end
  endgenerate

  assign cap_done = cap_en && (cap_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      res     <= '0;
      cap_cnt <= '0;
    end else if (cap_en) begin
      res     <= {ser_y, res[WIDTH-1:1]};
      cap_cnt <= cap_done ? '0 : cap_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serneg_ctrl.sv
// Sequences one word at a time through an external bit-serial negator:
// parallel in, LSB-first serial out, deserialised result back to parallel.
module serneg_ctrl
  import serneg_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SER_LAT = 1
) (
  input  logic     t_clk,
  input  logic     r_n,
  serneg_if.slave  bus,
  output logic     busy,
  output logic     ser_i,
  output logic     ser_r,
  input  logic     ser_y
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));

  state_t           state, state_nxt;
  logic [CNT_W-1:0] k;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] res;
  logic             ovf_q;
  logic             accept;
  logic             last_bit;
  logic             cap_done;

  assign accept   = (state == IDLE) && bus.in_valid;
  assign last_bit = (k == CNT_W'(WIDTH - 1));

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge t_clk or negedge r_n) begin
    if (!r_n) begin
      k     <= '0;
      shreg <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      k     <= '0;
      shreg <= bus.in_data;
      ovf_q <= (bus.in_data == MOST_NEG);
    end else if (state == SHIFT) begin
      k     <= last_bit ? '0 : k + CNT_W'(1);
      shreg <= {1'b0, shreg[WIDTH-1:1]};
    end
  end

  // ser_r is held high while idle so the negator's seen-one flag stays clear.
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = res;
    bus.out_ovf   = ovf_q;
    busy          = 1'b1;
    ser_i         = 1'b0;
    ser_r         = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        ser_r        = 1'b1;
        if (bus.in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        ser_i = shreg[0];
        ser_r = (k == '0);
        if (last_bit) state_nxt = (SER_LAT > 0) ? DRAIN : DONE;
      end
      DRAIN: begin
        if (cap_done) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  serneg_capture #(
    .WIDTH   (WIDTH),
    .SER_LAT (SER_LAT)
  ) u_capture (
    .t_clk    (t_clk),
    .r_n      (r_n),
    .issue    (state == SHIFT),
    .ser_y    (ser_y),
    .res      (res),
    .cap_done (cap_done)
  );

endmodule

// File: tb/tb_serneg_ctrl.sv
// Bench for serneg_ctrl: three instances (SER_LAT 1, 0, 3), each paired with a
// behavioural serial negator; results compared against plain arithmetic negation.
module tb_serneg_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         ovf;
  } vec_t;

  logic t_clk = 1'b0;
  logic r_n   = 1'b0;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  logic [2:0]          in_valid_v;
  logic [2:0]          out_ready_v;
  logic [2:0][W-1:0]   in_data_v;
  wire  [2:0]          in_ready_v;
  wire  [2:0]          out_valid_v;
  wire  [2:0]          out_ovf_v;
  wire  [2:0]          busy_v;
  wire  [2:0]          ser_i_v;
  wire  [2:0]          ser_r_v;
  wire  [2:0][W-1:0]   out_data_v;

  vec_t         vecs[6];
  logic [W-1:0] words[3];
  logic [W-1:0] corners[3];
  int           vcyc[3];

  always #5 t_clk = ~t_clk;
  always @(posedge t_clk) cyc = cyc + 1;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

      serneg_if #(.WIDTH(W)) bus ();
      logic       ser_y;
      logic       seen;
      logic       y_now;
      logic [3:0] ypipe;
      logic [4:0] ychain;

      assign bus.in_valid   = in_valid_v[g];
      assign bus.in_data    = in_data_v[g];
      assign bus.out_ready  = out_ready_v[g];
      assign in_ready_v[g]  = bus.in_ready;
      assign out_valid_v[g] = bus.out_valid;
      assign out_data_v[g]  = bus.out_data;
      assign out_ovf_v[g]   = bus.out_ovf;

      serneg_ctrl #(.WIDTH(W), .SER_LAT(LAT)) dut (
        .t_clk (t_clk),
        .r_n   (r_n),
        .bus   (bus.slave),
        .busy  (busy_v[g]),
        .ser_i (ser_i_v[g]),
        .ser_r (ser_r_v[g]),
        .ser_y (ser_y)
      );

      // Serial negator: copy bits up to and including the first 1, invert after it.
      assign y_now  = ser_i_v[g] ^ (seen & ~ser_r_v[g]);
      assign ychain = {ypipe, y_now};
      assign ser_y  = ychain[LAT];

      always @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
          seen  <= 1'b0;
          ypipe <= '0;
        end else begin
          seen  <= (seen & ~ser_r_v[g]) | ser_i_v[g];
          ypipe <= {ypipe[2:0], y_now};
        end
      end
    end
  endgenerate

  function automatic int lat_of(input int idx);
    return (idx == 0) ? 1 : ((idx == 1) ? 0 : 3);
  endfunction

  function automatic logic [W:0] model(input logic [W-1:0] d);
    int neg;
    neg = (256 - int'(d)) % 256;
    return {(d == 8'h80), 8'(neg)};
  endfunction

  task automatic step();
    @(posedge t_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [W-1:0] d, output int t0);
    int n;
    n = 0;
    while (in_ready_v[idx] !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check($sformatf("in_ready_timeout[%0d]", idx), 32'd0, 32'd1);
    in_valid_v[idx] = 1'b1;
    in_data_v[idx]  = d;
    t0 = cyc;
    step();
    in_valid_v[idx] = 1'b0;
    in_data_v[idx]  = 8'($urandom);
  endtask

  task automatic checkOutput(input int idx, input int t0, input logic [W-1:0] exp_d,
                             input logic exp_ovf, input int hold);
    int n;
    n = 0;
    while (out_valid_v[idx] !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check($sformatf("latency[%0d]", idx), 32'(cyc - t0), 32'(W + lat_of(idx) + 1));
    check($sformatf("out_data[%0d]", idx), 32'(out_data_v[idx]), 32'(exp_d));
    check($sformatf("out_ovf[%0d]", idx), 32'(out_ovf_v[idx]), 32'(exp_ovf));
    for (int h = 0; h < hold; h++) begin
      in_valid_v[idx] = 1'b1;
      in_data_v[idx]  = 8'($urandom);
      step();
      check($sformatf("hold_valid[%0d]", idx), 32'(out_valid_v[idx]), 32'd1);
      check($sformatf("hold_data[%0d]", idx), 32'(out_data_v[idx]), 32'(exp_d));
      check($sformatf("hold_in_ready[%0d]", idx), 32'(in_ready_v[idx]), 32'd0);
    end
    in_valid_v[idx]  = 1'b0;
    out_ready_v[idx] = 1'b1;
    step();
    out_ready_v[idx] = 1'b0;
    check($sformatf("valid_drop[%0d]", idx), 32'(out_valid_v[idx]), 32'd0);
    check($sformatf("idle_ready[%0d]", idx), 32'(in_ready_v[idx]), 32'd1);
  endtask

  initial begin
    int           t0;
    int           widx;
    int           ridx;
    int           idx;
    logic         acc;
    logic [W-1:0] d;
    logic [W-1:0] pat;
    logic [W:0]   m;

    in_valid_v  = '0;
    out_ready_v = '0;
    in_data_v   = '0;
    vecs[0] = '{8'h00, 8'h00, 1'b0};
    vecs[1] = '{8'h80, 8'h80, 1'b1};
    vecs[2] = '{8'h7F, 8'h81, 1'b0};
    vecs[3] = '{8'hFF, 8'h01, 1'b0};
    vecs[4] = '{8'h55, 8'hAB, 1'b0};
    vecs[5] = '{8'h40, 8'hC0, 1'b0};
    words   = '{8'h01, 8'h02, 8'h03};
    corners = '{8'h00, 8'h80, 8'hFF};

    repeat (2) @(posedge t_clk);
    #1;
    check("rst_out_valid", 32'(out_valid_v[0]), 32'd0);
    check("rst_out_data", 32'(out_data_v[0]), 32'd0);
    check("rst_out_ovf", 32'(out_ovf_v[0]), 32'd0);
    check("rst_busy", 32'(busy_v), 32'd0);
    check("rst_ser_i", 32'(ser_i_v), 32'd0);
    check("rst_ser_r", 32'(ser_r_v), 32'd7);
    check("rst_in_ready", 32'(in_ready_v), 32'd7);
    r_n = 1'b1;
    step();

    // Serial bit order and strobe for 8'h05.
    pat = 8'h05;
    applyStimulus(0, pat, t0);
    for (int k = 0; k < W; k++) begin
      check($sformatf("ser_i_bit%0d", k), 32'(ser_i_v[0]), 32'(pat[k]));
      check($sformatf("ser_r_bit%0d", k), 32'(ser_r_v[0]), 32'(k == 0));
      check($sformatf("busy_bit%0d", k), 32'(busy_v[0]), 32'd1);
      step();
    end
    checkOutput(0, t0, 8'hFB, 1'b0, 0);

    // Backpressure: result held 3 cycles while new in_valid is ignored.
    applyStimulus(0, 8'h01, t0);
    checkOutput(0, t0, 8'hFF, 1'b0, 3);

    // Asynchronous abort at bit 3.
    applyStimulus(0, 8'h33, t0);
    repeat (3) step();
    r_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid_v[0]), 32'd0);
    check("abort_ser_r", 32'(ser_r_v[0]), 32'd1);
    check("abort_busy", 32'(busy_v[0]), 32'd0);
    check("abort_in_ready", 32'(in_ready_v[0]), 32'd1);
    #2;
    r_n = 1'b1;
    step();
    applyStimulus(0, 8'h2A, t0);
    checkOutput(0, t0, 8'hD6, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, vecs[i].din, t0);
      checkOutput(0, t0, vecs[i].dout, vecs[i].ovf, i % 2);
    end

    // Back-to-back stream with both handshakes held high.
    widx = 0;
    ridx = 0;
    out_ready_v[0] = 1'b1;
    in_valid_v[0]  = 1'b1;
    in_data_v[0]   = words[0];
    for (int n = 0; n < 80 && ridx < 3; n++) begin
      if (out_valid_v[0] === 1'b1) begin
        m = model(words[ridx]);
        check($sformatf("stream_data%0d", ridx), 32'(out_data_v[0]), 32'(m[W-1:0]));
        vcyc[ridx] = cyc;
        ridx++;
      end
      acc = in_valid_v[0] && in_ready_v[0];
      step();
      if (acc) begin
        widx++;
        if (widx < 3) in_data_v[0] = words[widx];
        else          in_valid_v[0] = 1'b0;
      end
    end
    out_ready_v[0] = 1'b0;
    in_valid_v[0]  = 1'b0;
    check("stream_count", 32'(ridx), 32'd3);
    check("stream_gap01", 32'(vcyc[1] - vcyc[0]), 32'd11);
    check("stream_gap12", 32'(vcyc[2] - vcyc[1]), 32'd11);

    // Zero and three-cycle negator latency.
    applyStimulus(1, 8'h0C, t0);
    checkOutput(1, t0, 8'hF4, 1'b0, 0);
    applyStimulus(2, 8'h0C, t0);
    checkOutput(2, t0, 8'hF4, 1'b0, 1);

    for (int i = 0; i < 30; i++) begin
      idx = $urandom_range(0, 2);
      d = 8'($urandom);
      if ($urandom_range(0, 4) == 0) d = corners[$urandom_range(0, 2)];
      m = model(d);
      applyStimulus(idx, d, t0);
      checkOutput(idx, t0, m[W-1:0], m[W], $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
